button_conditioner: RTL and testbench

- Front end that converts raw, bouncy push-button inputs into clean, single-clock-domain signals for the system's button PIO inputs: set mode, increment hour, increment minute and confirm.
- Per button:
  - 2-flop synchronizer
  - debounce filter
  - press-edge detection
  - optional hold-to-auto-repeat, so holding an increment button steps the time continuously.
- Sits between the board keys and the system's button PIO exports.

---
 rtl/button_conditioner.sv | 171 +++++++++++++++++
 tb/tb_button_conditioner.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: per-bit synchronizer, debounce filter, press-edge
// detection and optional hold-to-auto-repeat, all outputs registered.
module button_conditioner #(
  parameter int                 NUM_BTN         = 4,
  parameter bit                 ACTIVE_LOW      = 1'b1,
  parameter int                 DEBOUNCE_CYCLES = 1000000,
  parameter int                 REPEAT_DELAY    = 25000000,
  parameter int                 REPEAT_RATE     = 10000000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = NUM_BTN'(4'b0110)
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic [NUM_BTN-1:0] btn_raw_i,
  output logic [NUM_BTN-1:0] btn_level_o,
  output logic [NUM_BTN-1:0] btn_press_o,
  output logic [NUM_BTN-1:0] btn_repeat_o,
  output logic [NUM_BTN-1:0] btn_event_o,
  output logic               any_event_o
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCNT_W = $clog2(RMAX + 1);

  localparam logic [CNT_W-1:0]   DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0]  RD_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0]  RR_LAST  = RCNT_W'(REPEAT_RATE - 1);
  localparam logic [NUM_BTN-1:0] RELEASED = {NUM_BTN{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_t;

  logic [NUM_BTN-1:0] sync_q1;
  logic [NUM_BTN-1:0] sync_q2;
  logic [NUM_BTN-1:0] sync_p;
  logic [NUM_BTN-1:0] press_d;
  logic [NUM_BTN-1:0] repeat_d;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, which is what makes the 2-flop chain work.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync_q1 <= RELEASED;
      sync_q2 <= RELEASED;
    end else begin
      sync_q1 <= btn_raw_i;
      sync_q2 <= sync_q1;
    end
  end

  assign sync_p = ACTIVE_LOW ? ~sync_q2 : sync_q2;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lvl_q;
    logic             lvl_d;

    always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path leaves a value unassigned and no latch is inferred.
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      if (sync_p[i] == lvl_q) begin
        cnt_d = '0;
      end else if (cnt_q == DB_LAST) begin
        lvl_d = sync_p[i];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
      end
    end

    assign btn_level_o[i] = lvl_q;
    // Press is taken from the incoming level so the registered pulse lines up
    // with the first cycle btn_level_o is high.
    assign press_d[i] = lvl_d & ~lvl_q;

    if (REPEAT_MASK[i]) begin : g_rep
      rep_state_t        state_q;
      rep_state_t        state_d;
      logic [RCNT_W-1:0] rcnt_q;
      logic [RCNT_W-1:0] rcnt_d;
      logic              fire_d;

      always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
          state_q <= IDLE;
          rcnt_q  <= '0;
        end else begin
          state_q <= state_d;
          rcnt_q  <= rcnt_d;
        end
      end

      // state_q/rcnt_q describe the current output cycle; the step below uses
      // that cycle's level and press to form the next cycle's state.
      always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        fire_d  = 1'b0;
        unique case (state_q)
          IDLE: begin
            if (btn_press_o[i]) begin
              state_d = DELAY;
              rcnt_d  = '0;
            end
          end
          DELAY: begin
            if (!lvl_q) begin
              state_d = IDLE;
            end else if (rcnt_q == RD_LAST) begin
              state_d = REPEAT;
              rcnt_d  = '0;
            end else begin
              rcnt_d = rcnt_q + RCNT_W'(1);
            end
          end
          REPEAT: begin
            if (!lvl_q) begin
              state_d = IDLE;
            end else if (rcnt_q == RR_LAST) begin
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt_q + RCNT_W'(1);
            end
          end
          default: state_d = IDLE;
        endcase
        // The pulse registers with the level it belongs to: a release arriving
        // on the terminal count suppresses it.
        if (lvl_d) begin
          if (state_d == DELAY && rcnt_d == RD_LAST) fire_d = 1'b1;
          if (state_d == REPEAT && rcnt_d == RR_LAST) fire_d = 1'b1;
        end
      end

      assign repeat_d[i] = fire_d;
    end else begin : g_norep
      assign repeat_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      btn_press_o  <= '0;
      btn_repeat_o <= '0;
      btn_event_o  <= '0;
      any_event_o  <= 1'b0;
    end else begin
      btn_press_o  <= press_d;
      btn_repeat_o <= repeat_d;
      btn_event_o  <= press_d | repeat_d;
      any_event_o  <= |(press_d | repeat_d);
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: window-based reference model pushes
// one expected record per cycle, a negedge monitor pops and compares.
module tb_button_conditioner;

  localparam int          NB   = 4;
  localparam int          DB   = 4;
  localparam int          RD   = 10;
  localparam int          RR   = 3;
  localparam logic [3:0]  MASK = 4'b0110;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] raw = 4'hF;
  logic [NB-1:0] level, press, rep, evt;
  logic          any;

  button_conditioner #(
    .NUM_BTN(NB), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_MASK(MASK)
  ) dut (
    .clk_clk(clk), .reset_reset(rst), .btn_raw_i(raw),
    .btn_level_o(level), .btn_press_o(press), .btn_repeat_o(rep),
    .btn_event_o(evt), .any_event_o(any)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] rep;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A level flips once the last DB synchronized samples, all taken since the
  // previous flip, disagree with it. Repeats fall at RD, RD+RR, ... cycles
  // after the press while the level stays high.
  logic [NB-1:0] m_dly1, m_dly2, m_level;
  logic [DB-1:0] m_win [NB];
  int            m_since [NB];
  int            m_held  [NB];

  task automatic model_reset();
    m_dly1  = '0;
    m_dly2  = '0;
    m_level = '0;
    for (int i = 0; i < NB; i++) begin
      m_win[i]   = '0;
      m_since[i] = 0;
      m_held[i]  = -1;
    end
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [NB-1:0] s_used, old_lvl;
    exp_t          e;
    s_used  = m_dly2;
    m_dly2  = m_dly1;
    m_dly1  = ~raw;
    old_lvl = m_level;
    e       = '0;
    for (int i = 0; i < NB; i++) begin
      m_win[i] = {m_win[i][DB-2:0], s_used[i]};
      m_since[i]++;
      if (m_since[i] >= DB && m_win[i] == {DB{~old_lvl[i]}}) begin
        m_level[i] = ~old_lvl[i];
        m_since[i] = 0;
      end
      e.press[i] = m_level[i] & ~old_lvl[i];
      if (!m_level[i])     m_held[i] = -1;
      else if (e.press[i]) m_held[i] = 0;
      else if (m_held[i] >= 0) m_held[i]++;
      e.rep[i] = MASK[i] && (m_held[i] >= RD) && ((m_held[i] - RD) % RR == 0);
    end
    e.level = m_level;
    exp_q.push_back(e);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // ---------------- monitor ----------------
  task automatic monitor_step();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got 0 expected records, need 1 at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("level",  level, e.level);
      check("press",  press, e.press);
      check("repeat", rep,   e.rep);
      check("event",  evt,   e.press | e.rep);
      check("any",    any,   |(e.press | e.rep));
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst) monitor_step();
  end

  // ---------------- stimulus helpers ----------------
  // kind: 0 = press, 1 = repeat, 2 = any event. n = negedges waited.
  task automatic wait_sig(input string name, input int kind, input int b, output int n);
    logic hit;
    n = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      n++;
      case (kind)
        0:       hit = press[b];
        1:       hit = rep[b];
        default: hit = any;
      endcase
      if (hit) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: got no pulse in 64 cycles, need 1", name);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    raw = 4'hF;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},  level, 0);
    check({tag, "_press"},  press, 0);
    check({tag, "_repeat"}, rep,   0);
    check({tag, "_event"},  evt,   0);
    check({tag, "_any"},    any,   0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, need $finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n, cnt, first, k_fall;
    int hold [NB];

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Clean press on bit 0
    raw[0] = 1'b0;
    n = 0;
    for (int k = 0; k < 20 && !level[0]; k++) begin
      @(negedge clk);
      n++;
    end
    check("clean_latency", n, 6);
    check("clean_press", press[0], 1);
    @(negedge clk);
    check("clean_press_width", press[0], 0);
    repeat (28) @(negedge clk);
    idle(12);

    // Bounce on bit 1: low 3, high 1, low and hold
    raw[1] = 1'b0;
    repeat (3) @(negedge clk);
    raw[1] = 1'b1;
    @(negedge clk);
    raw[1] = 1'b0;
    cnt = 0;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (press[1]) begin
        cnt++;
        if (first == 0) first = k;
      end
    end
    check("bounce_press_count", cnt, 1);
    check("bounce_latency", first, 6);
    idle(15);

    // Lone 3-cycle glitch on bit 3 never reaches the level
    raw[3] = 1'b0;
    repeat (3) @(negedge clk);
    raw[3] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (level[3]) cnt++;
    end
    check("glitch_level_cycles", cnt, 0);
    idle(5);

    // Auto-repeat on bit 2
    raw[2] = 1'b0;
    wait_sig("repeat_press", 0, 2, n);
    cnt = 0;
    k_fall = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (rep[2]) cnt++;
      if (!level[2] && k_fall == 0) k_fall = k;
      if (k == 33) raw[2] = 1'b1;
    end
    check("repeat_count", cnt, 10);
    check("release_latency", k_fall - 33, 6);
    idle(10);

    // Release landing on the first terminal count of bit 1
    raw[1] = 1'b0;
    wait_sig("term_press", 0, 1, n);
    cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rep[1]) cnt++;
      if (k == 9)  check("term_level_before", level[1], 1);
      if (k == 10) check("term_level_fall", level[1], 0);
      if (k == 4)  raw[1] = 1'b1;
    end
    check("term_repeat_count", cnt, 0);
    idle(10);

    // Simultaneous presses on bits 0 and 3
    raw[0] = 1'b0;
    raw[3] = 1'b0;
    wait_sig("simul", 2, 0, n);
    check("simul_event", evt, 4'b1001);
    check("simul_press", press, 4'b1001);
    @(negedge clk);
    check("simul_any_width", any, 0);
    repeat (5) @(negedge clk);
    idle(12);

    // Reset while bit 2 is repeating, key held through reset
    raw[2] = 1'b0;
    wait_sig("midrst_press", 0, 2, n);
    wait_sig("midrst_repeat", 1, 2, n);
    #1 rst = 1'b1;
    #1 check_all_zero("midrst");
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    wait_sig("midrst_repress", 0, 2, n);
    check("midrst_latency", n, 6);
    repeat (20) @(negedge clk);
    idle(12);

    // Randomized holds across all buttons, occasional reset
    for (int b = 0; b < NB; b++) hold[b] = $urandom_range(30, 1);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int b = 0; b < NB; b++) begin
        hold[b]--;
        if (hold[b] <= 0) begin
          raw[b]  = ~raw[b];
          hold[b] = ($urandom_range(3) == 0) ? $urandom_range(40, 12) : $urandom_range(8, 1);
        end
      end
      if ($urandom_range(399) == 0) begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
      end
    end

    idle(20);
    #1 check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
